// File: rtl/bus_ram_responder.sv
// Word-addressed RAM slave with programmable stall cycles and a fixed-latency read pipeline.
// Simultaneous read and write executes the write, drops the read and latches protocolError.
module bus_ram_responder #(
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2,
    parameter int DEPTH_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  bwe,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic        waitRequest,
    output logic        readValid,
    output logic [31:0] dataOut,
    output logic        protocolError
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nx;
    logic        w_req;
    logic        w_wait;
    logic        w_accept;
    logic        w_rd;
    logic        w_wr;
    logic [AW-1:0] w_idx;
    logic        w_unused;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [READ_LATENCY-1:0] r_vld;
    logic [31:0] r_dat [READ_LATENCY];
    logic        r_perr;

    assign w_req    = read | write;
    assign w_idx    = address[AW+1:2];
    assign w_unused = ^{address[31:AW+2], address[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Accept only when cnt has run out, so each command sees WAIT_STATES stalls.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_wait     = 1'b0;
        w_accept   = 1'b0;
        if (!reset) begin
            w_state_nx = IDLE;
            w_cnt_nx   = 3'd0;
        end else if (WAIT_STATES == 0) begin
            w_accept = w_req;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        w_wait     = 1'b1;
                        w_cnt_nx   = 3'(WAIT_STATES - 1);
                        w_state_nx = STALL;
                    end
                end
                STALL: begin
                    if (!w_req) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = 3'd0;
                    end else if (r_cnt != 3'd0) begin
                        w_wait   = 1'b1;
                        w_cnt_nx = r_cnt - 3'd1;
                    end else begin
                        w_accept   = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 3'd0;
                end
            endcase
        end
    end

    assign w_wr = w_accept & write;
    assign w_rd = w_accept & read & ~write;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bwe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dataIn[8*i +: 8];
                end
            end
        end
    end

    // Data is captured at acceptance and zeroed in empty slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dat[i] <= 32'd0;
            end
        end else begin
            r_vld[0] <= w_rd;
            r_dat[0] <= w_rd ? r_mem[w_idx] : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else if (w_accept && read && write) begin
            r_perr <= 1'b1;
        end
    end

    assign waitRequest   = w_wait;
    assign readValid     = r_vld[READ_LATENCY-1];
    assign dataOut       = r_vld[READ_LATENCY-1] ? r_dat[READ_LATENCY-1] : 32'd0;
    assign protocolError = r_perr;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: instance A (1 wait state, latency 2), instance B (0 wait states, latency 3).
// Inputs change on falling edges or just after rising edges; outputs are checked on falling edges.
module tb_bus_ram_responder;

    logic clk;
    logic reset;

    logic        a_rd, a_wr;
    logic [3:0]  a_be;
    logic [31:0] a_ad, a_di;
    logic        a_wait, a_rv, a_perr;
    logic [31:0] a_dout;

    logic        b_rd, b_wr;
    logic [3:0]  b_be;
    logic [31:0] b_ad, b_di;
    logic        b_wait, b_rv, b_perr;
    logic [31:0] b_dout;

    int n_cmp = 0;
    int n_err = 0;

    bus_ram_responder #(
        .WAIT_STATES (1),
        .READ_LATENCY(2),
        .DEPTH_WORDS (1024)
    ) u_a (
        .clk          (clk),
        .reset        (reset),
        .read         (a_rd),
        .write        (a_wr),
        .bwe          (a_be),
        .address      (a_ad),
        .dataIn       (a_di),
        .waitRequest  (a_wait),
        .readValid    (a_rv),
        .dataOut      (a_dout),
        .protocolError(a_perr)
    );

    bus_ram_responder #(
        .WAIT_STATES (0),
        .READ_LATENCY(3),
        .DEPTH_WORDS (1024)
    ) u_b (
        .clk          (clk),
        .reset        (reset),
        .read         (b_rd),
        .write        (b_wr),
        .bwe          (b_be),
        .address      (b_ad),
        .dataIn       (b_di),
        .waitRequest  (b_wait),
        .readValid    (b_rv),
        .dataOut      (b_dout),
        .protocolError(b_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic a_op(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] ad, input logic [31:0] dt);
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_be = be; a_ad = ad; a_di = dt;
        #1 chk("a_wait_on", {31'd0, a_wait}, 32'd1);
        @(negedge clk);
        chk("a_wait_off", {31'd0, a_wait}, 32'd0);
        @(posedge clk);
        #1 a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic a_rdchk(input logic [31:0] ad, input logic [31:0] exp);
        a_op(1'b1, 1'b0, 4'h0, ad, 32'd0);
        @(negedge clk);
        chk("a_rv_early", {31'd0, a_rv}, 32'd0);
        @(negedge clk);
        chk("a_rv", {31'd0, a_rv}, 32'd1);
        chk("a_data", a_dout, exp);
        @(negedge clk);
        chk("a_rv_after", {31'd0, a_rv}, 32'd0);
        chk("a_dout_idle", a_dout, 32'd0);
    endtask

    task automatic b_rdchk(input logic [31:0] ad, input logic [31:0] exp);
        @(negedge clk);
        b_rd = 1'b1; b_ad = ad;
        #1 chk("b_wait", {31'd0, b_wait}, 32'd0);
        @(posedge clk);
        #1 b_rd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("b_rv_early", {31'd0, b_rv}, 32'd0);
        end
        @(negedge clk);
        chk("b_rv", {31'd0, b_rv}, 32'd1);
        chk("b_data", b_dout, exp);
        @(negedge clk);
        chk("b_rv_after", {31'd0, b_rv}, 32'd0);
        chk("b_dout_idle", b_dout, 32'd0);
    endtask

    logic [31:0] vals [4];

    initial begin
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        vals[3] = 32'h4444_4444;
        reset = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_be = 4'h0; a_ad = 32'd0; a_di = 32'd0;
        b_rd = 1'b0; b_wr = 1'b0; b_be = 4'h0; b_ad = 32'd0; b_di = 32'd0;

        #2;
        chk("rst_a_wait", {31'd0, a_wait}, 32'd0);
        chk("rst_a_rv", {31'd0, a_rv}, 32'd0);
        chk("rst_a_dout", a_dout, 32'd0);
        chk("rst_a_perr", {31'd0, a_perr}, 32'd0);
        chk("rst_b_rv", {31'd0, b_rv}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic write then read with one stall cycle each
        a_op(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        a_rdchk(32'h10, 32'hDEAD_BEEF);

        // byte enables
        a_op(1'b0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
        a_op(1'b0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        a_rdchk(32'h20, 32'hAA22_CC44);

        // aliasing and ignored low bits
        a_op(1'b0, 1'b1, 4'hF, 32'h1000, 32'h0000_0005);
        a_rdchk(32'h0, 32'h0000_0005);
        a_rdchk(32'h13, 32'hDEAD_BEEF);

        // bwe=0 write leaves memory unchanged
        a_op(1'b0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF);
        a_rdchk(32'h10, 32'hDEAD_BEEF);

        // request withdrawn during stall: nothing accepted
        @(negedge clk);
        a_rd = 1'b1; a_ad = 32'h20;
        #1 chk("a_drop_wait_on", {31'd0, a_wait}, 32'd1);
        @(posedge clk);
        #1 a_rd = 1'b0;
        #1 chk("a_drop_wait_off", {31'd0, a_wait}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("a_drop_no_rv", {31'd0, a_rv}, 32'd0);
        end

        // read and write together
        a_op(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("a_rw_no_rv", {31'd0, a_rv}, 32'd0);
            chk("a_perr_set", {31'd0, a_perr}, 32'd1);
        end
        a_rdchk(32'h40, 32'h1234_5678);
        chk("a_perr_sticky", {31'd0, a_perr}, 32'd1);
        chk("b_perr_clear", {31'd0, b_perr}, 32'd0);

        // back-to-back writes with no wait states
        b_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_wr = 1'b1; b_ad = 32'(4 * k); b_di = vals[k];
            #1 chk("b_wr_wait", {31'd0, b_wait}, 32'd0);
        end
        @(negedge clk);
        b_wr = 1'b0;

        // four reads back-to-back: valid on four consecutive cycles
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 4 && k <= 7) begin
                chk("b_burst_rv", {31'd0, b_rv}, 32'd1);
                chk("b_burst_data", b_dout, vals[k-4]);
            end else begin
                chk("b_burst_idle", {31'd0, b_rv}, 32'd0);
            end
            if (k <= 4) begin
                b_rd = 1'b1; b_ad = 32'(4 * (k - 1));
                #1 chk("b_burst_wait", {31'd0, b_wait}, 32'd0);
            end else begin
                b_rd = 1'b0;
            end
        end

        // reset one cycle after a read acceptance
        @(negedge clk);
        b_rd = 1'b1; b_ad = 32'h4;
        @(posedge clk);
        #1 b_rd = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        b_wr = 1'b1; b_be = 4'hF; b_ad = 32'h80; b_di = 32'h0000_0077;
        a_wr = 1'b1; a_be = 4'hF; a_ad = 32'h10; a_di = 32'h0BAD_0BAD;
        #1;
        chk("rst2_b_rv", {31'd0, b_rv}, 32'd0);
        chk("rst2_b_dout", b_dout, 32'd0);
        chk("rst2_b_wait", {31'd0, b_wait}, 32'd0);
        chk("rst2_a_wait", {31'd0, a_wait}, 32'd0);
        chk("rst2_a_perr", {31'd0, a_perr}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst2_b_rv_held", {31'd0, b_rv}, 32'd0);
            chk("rst2_a_rv_held", {31'd0, a_rv}, 32'd0);
        end
        reset = 1'b1;
        a_wr = 1'b0;
        @(posedge clk);
        #1 b_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_rv", {31'd0, b_rv}, 32'd0);
        end

        // first-edge write after reset landed; memory survived reset
        b_rdchk(32'h80, 32'h0000_0077);
        a_rdchk(32'h10, 32'hDEAD_BEEF);
        chk("a_perr_after_rst", {31'd0, a_perr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
